// File: rtl/game_pkg.sv
// Shared definitions for the game top level: requester indices, servo limits
// and the servo arbiter state encoding.
package game_pkg;

    localparam int REQ_EV1 = 0;
    localparam int REQ_EV2 = 1;
    localparam int REQ_PUZ = 2;
    localparam int NUM_REQ = 3;

    localparam logic [7:0] SERVO_DEFAULT_ANGLE = 8'd90;
    localparam logic [7:0] SERVO_MAX_ANGLE     = 8'd180;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_RETURN = 2'd2
    } arb_state_t;

    // One-hot of the lowest set bit; bit 0 is the highest-priority requester.
    function automatic logic [NUM_REQ-1:0] first_req(input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] pick;
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                pick = '0;
                pick[i] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [7:0] clamp_angle(input logic [7:0] a, input logic [7:0] lim);
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/slew_limiter.sv
// Moves angle_out one degree toward target on every step_tick from a
// free-running divider; the divider is never restarted by target changes.
module slew_limiter
    import game_pkg::*;
#(
    parameter int unsigned STEP_DIV      = 250_000,
    parameter logic [7:0]  DEFAULT_ANGLE = SERVO_DEFAULT_ANGLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] target,
    output logic [7:0] angle_out,
    output logic       at_target,
    output logic       step_tick
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign step_tick = (div_cnt == DIV_LAST);
    assign at_target = (angle_out == target);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            angle_out <= DEFAULT_ANGLE;
        end else begin
            div_cnt <= step_tick ? '0 : div_cnt + 1'b1;
            if (step_tick) begin
                if (angle_out < target) begin
                    angle_out <= angle_out + 8'd1;
                end else if (angle_out > target) begin
                    angle_out <= angle_out - 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/servo_arbiter.sv
// Fixed-priority owner arbitration for the single servo with a minimum hold
// time and a slew-limited return to the park angle when nobody owns it.
module servo_arbiter
    import game_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 5_000_000,
    parameter int unsigned STEP_DIV      = 250_000,
    parameter logic [7:0]  DEFAULT_ANGLE = SERVO_DEFAULT_ANGLE,
    parameter logic [7:0]  MAX_ANGLE     = SERVO_MAX_ANGLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [7:0]       angle0,
    input  logic [7:0]       angle1,
    input  logic [7:0]       angle2,
    output logic [2:0]       grant,
    output logic [7:0]       angle_out,
    output logic             at_target,
    output logic             busy,
    output arb_state_t       state
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    arb_state_t        next_state;
    logic [2:0]        next_grant;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] next_hold;
    logic [7:0]        target;
    logic [7:0]        next_target;
    logic [2:0]        pick;
    logic              preempt;
    logic              owner_req;
    logic              step_tick;

    assign pick = first_req(req);
    // With a one-hot owner, grant-1 masks exactly the higher-priority bits.
    assign preempt   = |(req & (grant - 3'd1));
    assign owner_req = |(req & grant);

    always_comb begin
        next_state = state;
        next_grant = grant;
        next_hold  = (hold_cnt != '0) ? hold_cnt - 1'b1 : '0;
        case (state)
            ARB_IDLE, ARB_RETURN: begin
                if (|req) begin
                    next_state = ARB_OWNED;
                    next_grant = pick;
                    next_hold  = HOLD_LOAD;
                end else if (state == ARB_RETURN && angle_out == DEFAULT_ANGLE) begin
                    next_state = ARB_IDLE;
                end
            end
            ARB_OWNED: begin
                if (preempt) begin
                    next_grant = pick;
                    next_hold  = HOLD_LOAD;
                end else if (!owner_req && hold_cnt == '0) begin
                    if (|req) begin
                        next_grant = pick;
                        next_hold  = HOLD_LOAD;
                    end else begin
                        next_grant = 3'b000;
                        next_state = ARB_RETURN;
                    end
                end
            end
            default: begin
                next_state = ARB_IDLE;
                next_grant = 3'b000;
                next_hold  = '0;
            end
        endcase
    end

    // Target follows the owner's live angle every cycle it stays granted.
    always_comb begin
        next_target = DEFAULT_ANGLE;
        case (next_grant)
            3'b001:  next_target = clamp_angle(angle0, MAX_ANGLE);
            3'b010:  next_target = clamp_angle(angle1, MAX_ANGLE);
            3'b100:  next_target = clamp_angle(angle2, MAX_ANGLE);
            default: next_target = DEFAULT_ANGLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            grant    <= 3'b000;
            hold_cnt <= '0;
            busy     <= 1'b0;
            target   <= DEFAULT_ANGLE;
        end else begin
            state    <= next_state;
            grant    <= next_grant;
            hold_cnt <= next_hold;
            busy     <= (next_state != ARB_IDLE);
            target   <= next_target;
        end
    end

    slew_limiter #(
        .STEP_DIV      (STEP_DIV),
        .DEFAULT_ANGLE (DEFAULT_ANGLE)
    ) u_slew (
        .clk       (clk),
        .rst       (rst),
        .target    (target),
        .angle_out (angle_out),
        .at_target (at_target),
        .step_tick (step_tick)
    );

endmodule

// File: tb/tb_servo_arbiter.sv
// Bench for servo_arbiter: directed scenarios plus random traffic, all
// compared each cycle against a cycle-level ownership/slew reference model.
module tb_servo_arbiter;
    import game_pkg::*;

    localparam int HOLD = 8;
    localparam int STEP = 4;
    localparam int DEF  = 90;
    localparam int MAXA = 180;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [7:0] angle0 = 8'd0;
    logic [7:0] angle1 = 8'd0;
    logic [7:0] angle2 = 8'd0;
    logic [2:0] grant;
    logic [7:0] angle_out;
    logic       at_target;
    logic       busy;
    arb_state_t state;
    logic [14:0] dut_obs;
    logic [14:0] e;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: owner index (-1 = none), returning flag, hold remaining,
    // divider phase, current angle and registered target as plain integers.
    int m_owner = -1;
    int m_ret = 0;
    int m_hold = 0;
    int m_div = 0;
    int m_angle = DEF;
    int m_target = DEF;

    servo_arbiter #(
        .HOLD_CYCLES (HOLD),
        .STEP_DIV    (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .angle0    (angle0),
        .angle1    (angle1),
        .angle2    (angle2),
        .grant     (grant),
        .angle_out (angle_out),
        .at_target (at_target),
        .busy      (busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    assign dut_obs = {grant, angle_out, at_target, busy, state};

    function automatic logic [14:0] model_obs();
        logic [2:0] g;
        arb_state_t s;
        g = 3'b000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        if (m_owner >= 0) s = ARB_OWNED;
        else if (m_ret != 0) s = ARB_RETURN;
        else s = ARB_IDLE;
        return {g, 8'(m_angle), (m_angle == m_target), ((m_owner >= 0) || (m_ret != 0)), s};
    endfunction

    task automatic tick();
        int first, n_owner, n_ret, n_hold, n_div, n_angle, n_target;
        int ang[3];
        ang[0] = angle0; ang[1] = angle1; ang[2] = angle2;
        first = -1;
        for (int i = 2; i >= 0; i--) if (req[i]) first = i;
        n_owner = m_owner; n_ret = m_ret;
        n_hold = (m_hold > 0) ? m_hold - 1 : 0;
        n_div = (m_div == STEP - 1) ? 0 : m_div + 1;
        n_angle = m_angle;
        if (m_div == STEP - 1) begin
            if (m_angle < m_target) n_angle = m_angle + 1;
            else if (m_angle > m_target) n_angle = m_angle - 1;
        end
        if (m_owner < 0) begin
            if (first >= 0) begin
                n_owner = first; n_hold = HOLD - 1; n_ret = 0;
            end else if (m_ret != 0 && m_angle == DEF) begin
                n_ret = 0;
            end
        end else if (first >= 0 && first < m_owner) begin
            n_owner = first; n_hold = HOLD - 1;
        end else if (!req[m_owner] && m_hold == 0) begin
            if (first >= 0) begin
                n_owner = first; n_hold = HOLD - 1;
            end else begin
                n_owner = -1; n_ret = 1;
            end
        end
        n_target = (n_owner >= 0) ? ((ang[n_owner] > MAXA) ? MAXA : ang[n_owner]) : DEF;
        if (rst) begin
            n_owner = -1; n_ret = 0; n_hold = 0; n_div = 0; n_angle = DEF; n_target = DEF;
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_ret = n_ret; m_hold = n_hold;
        m_div = n_div; m_angle = n_angle; m_target = n_target;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 3'b000;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        e = model_obs();
        n_cmp++;
        if (dut_obs !== e || angle_out !== 8'd90 || at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            e = model_obs();
            n_cmp++;
            if (dut_obs !== e || grant !== 3'b000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
            end
        end
    endtask

    task automatic test_grant_hold_return();
        int held;
        do_reset();
        angle2 = 8'd100; req = 3'b100;
        tick();
        n_cmp++;
        if (grant !== 3'b100) begin
            n_fail++;
            $display("FAIL grant_latency cyc=%0d got=%b exp=100", cyc, grant);
        end
        held = 1;
        tick(); tick();
        held += 2;
        req = 3'b000;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (grant == 3'b100) held++;
            e = model_obs();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++;
                $display("FAIL grant_return cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
            end
        end
        n_cmp++;
        if (held !== HOLD || state !== ARB_IDLE || angle_out !== 8'd90) begin
            n_fail++;
            $display("FAIL min_hold cyc=%0d held=%0d exp=%0d state=%0d angle=%0d", cyc, held, HOLD, state, angle_out);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        angle2 = 8'd120; req = 3'b100;
        for (int i = 0; i < 200 && m_angle != 120; i++) begin
            tick();
            e = model_obs();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++;
                $display("FAIL preempt_rise cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
            end
        end
        n_cmp++;
        if (angle_out !== 8'd120 || at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_120 cyc=%0d got=%0d/%b exp=120/1", cyc, angle_out, at_target);
        end
        tick();
        angle0 = 8'd30; req = 3'b101;
        tick();
        n_cmp++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL preempt_grant cyc=%0d got=%b exp=001", cyc, grant);
        end
        for (int i = 0; i < 400; i++) begin
            tick();
            e = model_obs();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++;
                $display("FAIL preempt_fall cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
            end
        end
        n_cmp++;
        if (angle_out !== 8'd30 || at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_30 cyc=%0d got=%0d/%b exp=30/1", cyc, angle_out, at_target);
        end
    endtask

    task automatic test_low_priority_wait();
        do_reset();
        angle1 = 8'd60; angle2 = 8'd150; req = 3'b010;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) req = 3'b110;
            tick();
            e = model_obs();
            n_cmp++;
            if (dut_obs !== e || grant !== 3'b010) begin
                n_fail++;
                $display("FAIL low_prio_wait cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
            end
        end
        req = 3'b100;
        tick();
        n_cmp++;
        if (grant !== 3'b100 || state !== ARB_OWNED || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL handover cyc=%0d got grant=%b state=%0d busy=%b exp 100/1/1", cyc, grant, state, busy);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            e = model_obs();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++;
                $display("FAIL handover_run cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
            end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        angle1 = 8'd250; req = 3'b010;
        for (int i = 0; i < 400; i++) begin
            tick();
            e = model_obs();
            n_cmp++;
            if (dut_obs !== e || angle_out > 8'd180) begin
                n_fail++;
                $display("FAIL clamp_run cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
            end
        end
        n_cmp++;
        if (angle_out !== 8'd180 || at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_final cyc=%0d got=%0d/%b exp=180/1", cyc, angle_out, at_target);
        end
    endtask

    task automatic test_reset_mid_return();
        int found;
        do_reset();
        angle2 = 8'd140; req = 3'b100;
        for (int i = 0; i < 220; i++) tick();
        req = 3'b000;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (state == ARB_RETURN) found = 1;
        end
        e = model_obs();
        n_cmp++;
        if (found == 0 || dut_obs !== e || angle_out !== 8'd140) begin
            n_fail++;
            $display("FAIL enter_return cyc=%0d got=%h exp=%h found=%0d", cyc, dut_obs, e, found);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = model_obs();
        n_cmp++;
        if (dut_obs !== e || angle_out !== 8'd90 || grant !== 3'b000 || state !== ARB_IDLE) begin
            n_fail++;
            $display("FAIL reset_in_return cyc=%0d got=%h exp=%h", cyc, dut_obs, e);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) req[$urandom_range(0, 2)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) angle0 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 40) == 0) angle1 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 40) == 0) angle2 = 8'($urandom_range(0, 255));
            rst = ($urandom_range(0, 999) == 0);
            tick();
            e = model_obs();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++;
                $display("FAIL random cyc=%0d req=%b got=%h exp=%h", cyc, req, dut_obs, e);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_grant_hold_return();
        test_preempt();
        test_low_priority_wait();
        test_clamp();
        test_reset_mid_return();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
